// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift left/right, parallel load.
// Counts shifts per WIDTH-bit word and pulses RDY on word completion.
module univ_shift_reg #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             C,
    input  logic             R,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             SIR,
    input  logic             SIL,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] PO,
    output logic             SOL,
    output logic             SOR,
    output logic [CW-1:0]    CNT,
    output logic             RDY
);

    localparam logic [1:0]    M_HOLD  = 2'b00;
    localparam logic [1:0]    M_LEFT  = 2'b01;
    localparam logic [1:0]    M_RIGHT = 2'b10;
    localparam logic [1:0]    M_LOAD  = 2'b11;
    localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_po;
    logic [CW-1:0]    r_cnt;
    logic             r_rdy;

    logic             w_shift;
    logic             w_wrap;
    logic [WIDTH-1:0] w_po_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_rdy_nxt;

    // A shift in either direction advances the same word counter.
    assign w_shift = EN && (MODE == M_LEFT || MODE == M_RIGHT);
    assign w_wrap  = (r_cnt == LAST);

    // Next-state selection for the data register.
    always_comb begin
        w_po_nxt = r_po;
        if (EN) begin
            unique case (MODE)
                M_HOLD:  w_po_nxt = r_po;
                M_LEFT:  w_po_nxt = {r_po[WIDTH-2:0], SIR};
                M_RIGHT: w_po_nxt = {SIL, r_po[WIDTH-1:1]};
                M_LOAD:  w_po_nxt = D;
                default: w_po_nxt = r_po;
            endcase
        end
    end

    // Next-state selection for the word counter and completion pulse.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_rdy_nxt = 1'b0;
        if (w_shift) begin
            if (w_wrap) begin
                w_cnt_nxt = '0;
                w_rdy_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end else if (EN && MODE == M_LOAD) begin
            // A load aborts any partial word.
            w_cnt_nxt = '0;
        end
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge C) begin
        if (R) begin
            r_po  <= '0;
            r_cnt <= '0;
            r_rdy <= 1'b0;
        end else begin
            r_po  <= w_po_nxt;
            r_cnt <= w_cnt_nxt;
            r_rdy <= w_rdy_nxt;
        end
    end

    assign PO  = r_po;
    assign CNT = r_cnt;
    assign RDY = r_rdy;
    assign SOL = r_po[WIDTH-1];
    assign SOR = r_po[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: integer reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic          clk = 1'b0;
    logic          r_in = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          sir = 1'b0;
    logic          sil = 1'b0;
    logic [W-1:0]  d = '0;
    logic [W-1:0]  po;
    logic          sol;
    logic          sor;
    logic [CW-1:0] cnt;
    logic          rdy;

    int checks = 0;
    int errors = 0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .C(clk), .R(r_in), .EN(en), .MODE(mode),
        .SIR(sir), .SIL(sil), .D(d),
        .PO(po), .SOL(sol), .SOR(sor), .CNT(cnt), .RDY(rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: value as an integer, shifts-in-word as a plain count.
    int m_po = 0;
    int m_n = 0;
    int m_rdy = 0;
    bit m_valid = 0;

    always @(posedge clk) begin
        if (r_in) begin
            m_po = 0; m_n = 0; m_rdy = 0; m_valid = 1;
        end else if (en) begin
            m_rdy = 0;
            if (mode == 2'b11) begin
                m_po = int'(d); m_n = 0;
            end else if (mode != 2'b00) begin
                if (mode == 2'b01) m_po = (m_po * 2 + int'(sir)) % (1 << W);
                else m_po = m_po / 2 + int'(sil) * (1 << (W - 1));
                m_n = m_n + 1;
                if (m_n == W) begin
                    m_n = 0; m_rdy = 1;
                end
            end
        end else begin
            m_rdy = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("po", int'(po), m_po);
            chk("sol", int'(sol), (m_po >> (W - 1)) & 1);
            chk("sor", int'(sor), m_po & 1);
            chk("cnt", int'(cnt), m_n);
            chk("rdy", int'(rdy), m_rdy);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input logic rr, input logic e, input logic [1:0] m,
                        input logic sr, input logic sl, input logic [W-1:0] dd);
        @(negedge clk);
        r_in = rr; en = e; mode = m; sir = sr; sil = sl; d = dd;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] bits_l;
    int rdy_cyc[$];

    initial begin
        // Reset and load scenario
        step(1, 0, 2'b00, 0, 0, 8'h00);
        chk("rst0_po", int'(po), 0);
        step(0, 1, 2'b11, 0, 0, 8'hFF);
        chk("load_ff", int'(po), 8'hFF);
        step(1, 1, 2'b11, 1, 1, 8'h3C);
        chk("rst_po", int'(po), 0);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_rdy", int'(rdy), 0);
        chk("rst_sol", int'(sol), 0);
        chk("rst_sor", int'(sor), 0);

        // Shift-left word
        bits_l = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 2'b01, bits_l[7 - i], 0, 8'h00);
            if (i < 7) chk("sl_rdy_lo", int'(rdy), 0);
        end
        chk("sl_po", int'(po), 8'hB2);
        chk("sl_sol", int'(sol), 1);
        chk("sl_cnt", int'(cnt), 0);
        chk("sl_rdy", int'(rdy), 1);
        step(0, 1, 2'b00, 0, 0, 8'h00);
        chk("sl_rdy_one", int'(rdy), 0);

        // Load then shift right
        step(0, 1, 2'b11, 0, 0, 8'hA5);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 2'b10, 0, 0, 8'h00);
            chk("sr_rdy", int'(rdy), 0);
        end
        chk("sr_po", int'(po), 8'h0A);
        chk("sr_sor", int'(sor), 0);
        chk("sr_cnt", int'(cnt), 4);

        // Enable / hold
        step(0, 1, 2'b11, 0, 0, 8'h0B);
        step(0, 1, 2'b01, 0, 0, 8'h00);
        step(0, 1, 2'b01, 1, 0, 8'h00);
        step(0, 1, 2'b01, 0, 0, 8'h00);
        chk("h_pre_po", int'(po), 8'h5A);
        chk("h_pre_cnt", int'(cnt), 3);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) step(0, 0, 2'b01, 1, 1, 8'hFF);
            else step(0, 1, 2'b00, 1, 1, 8'hFF);
            chk("h_po", int'(po), 8'h5A);
            chk("h_cnt", int'(cnt), 3);
            chk("h_rdy", int'(rdy), 0);
        end

        // Abort by load
        step(0, 1, 2'b11, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 1, 2'b01, 1, 0, 8'h00);
        step(0, 1, 2'b11, 0, 0, 8'h00);
        chk("ab_rdy_load", int'(rdy), 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 2'b01, 1, 0, 8'h00);
            if (i < 7) chk("ab_rdy_lo", int'(rdy), 0);
        end
        chk("ab_rdy", int'(rdy), 1);
        chk("ab_po", int'(po), 8'hFF);

        // Mixed directions keep counting
        step(0, 1, 2'b11, 0, 0, 8'h81);
        for (int i = 0; i < 8; i++) step(0, 1, (i % 2 == 0) ? 2'b01 : 2'b10, 1, 0, 8'h00);
        chk("mix_rdy", int'(rdy), 1);

        // Reset mid-word then two back-to-back words
        for (int i = 0; i < 6; i++) step(0, 1, 2'b01, 1, 0, 8'h00);
        step(1, 1, 2'b01, 1, 1, 8'h00);
        chk("rm_po", int'(po), 0);
        chk("rm_cnt", int'(cnt), 0);
        chk("rm_rdy", int'(rdy), 0);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 2'b10, 0, 1, 8'h00);
            if (rdy === 1'b1) rdy_cyc.push_back(cyc);
        end
        chk("rm_npulse", rdy_cyc.size(), 2);
        if (rdy_cyc.size() == 2)
            chk("rm_gap", rdy_cyc[1] - rdy_cyc[0], 8);

        // Pseudo-random traffic against the model
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 5) != 0),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
